// File: rtl/iterative_divider_pkg.sv
// Shared types and opcode helpers for the execute-stage iterative divider.
//   ulong_t / long_t : 64-bit unsigned / signed machine words
//   opcode_t         : execute-stage opcodes (ALU ops plus the four divide ops)
//   div_state_t      : divider FSM states
//   isDivOp()        : true for UDIV, UMOD, SDIV, SMOD
//   isSignedDivOp()  : true for SDIV, SMOD
package iterative_divider_pkg;

  localparam int ULONG_W = 64;

  typedef logic        [ULONG_W-1:0] ulong_t;
  typedef logic signed [ULONG_W-1:0] long_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_INC  = 4'd3,
    OP_DEC  = 4'd4,
    OP_UDIV = 4'd5,
    OP_UMOD = 4'd6,
    OP_SDIV = 4'd7,
    OP_SMOD = 4'd8
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } div_state_t;

  function automatic logic isDivOp(input opcode_t op);
    return (op == OP_UDIV) || (op == OP_UMOD) || (op == OP_SDIV) || (op == OP_SMOD);
  endfunction

  function automatic logic isSignedDivOp(input opcode_t op);
    return (op == OP_SDIV) || (op == OP_SMOD);
  endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// One combinational radix-2 restoring division step.
//   rem      : current partial remainder (always < divisor)
//   divisor  : divisor magnitude
//   next_bit : next dividend bit shifted into the remainder
//   rem_next : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this step
module iterative_divider_div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted  = {rem, next_bit};
    // Because rem < divisor, shifted < 2*divisor, so whenever the subtraction
    // succeeds its result fits in WIDTH bits and the low-order difference is exact.
    q_bit    = (shifted >= {1'b0, divisor});
    diff     = shifted[WIDTH-1:0] - divisor;
    rem_next = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider (UDIV, UMOD, SDIV, SMOD).
// Optional macro: ITERATIVE_DIVIDER_EARLY_OUT_EN -- skips the leading-zero
// steps of the dividend magnitude; results are identical, latency shorter.
// Ports:
//   clk, rstN                 : clock, asynchronous active-low reset
//   reqValid/reqReady, op,a,b : request channel
//     Handshake: a transfer happens on a rising edge where valid && ready;
//     the producer holds its payload stable while valid is high and ready low.
//   rspValid/rspReady, result : response channel (same handshake rule)
//   divByZero, zero, negative, carry : registered result flags
//   fsm_state                 : current FSM state, for observation
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             reqValid,
  output logic             reqReady,
  input  opcode_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] result,
  output logic             divByZero,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output div_state_t       fsm_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state, next_state;
  opcode_t          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] b_mag_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dq_q;     // dividend bits shift out the top, quotient bits in at the bottom
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q, zero_q, neg_q;

  // SETUP-stage decode of the latched request
  logic             signed_op, is_mod, b_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    signed_op = isSignedDivOp(op_q);
    is_mod    = (op_q == OP_UMOD) || (op_q == OP_SMOD);
    b_zero    = (b_q == '0);
    ovf       = signed_op && (a_q == MOST_NEG) && (b_q == '1);
    a_mag     = (signed_op && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    b_mag     = (signed_op && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
  end

`ifdef ITERATIVE_DIVIDER_EARLY_OUT_EN
  localparam int LZ_W = $clog2(WIDTH + 1);
  logic [LZ_W-1:0] lz;

  // Leading zeros of the dividend magnitude; WIDTH when the dividend is 0.
  always_comb begin
    lz = LZ_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a_mag[i]) lz = LZ_W'(WIDTH - 1 - i);
    end
  end
`endif

  // Single restoring step
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  iterative_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .divisor  (b_mag_q),
    .next_bit (dq_q[WIDTH-1]),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= next_state;
  end

  // FSM: next state and handshake outputs
  always_comb begin
    next_state = state;
    reqReady   = 1'b0;
    rspValid   = 1'b0;
    case (state)
      IDLE: begin
        reqReady = 1'b1;
        // Non-divide opcodes are consumed here and silently dropped.
        if (reqValid && isDivOp(op)) next_state = SETUP;
      end
      SETUP: begin
        if (b_zero || ovf) begin
          next_state = DONE;
        end else begin
`ifdef ITERATIVE_DIVIDER_EARLY_OUT_EN
          next_state = (lz == LZ_W'(WIDTH)) ? FIXUP : ITER;
`else
          next_state = ITER;
`endif
        end
      end
      ITER:    if (cnt_q == '0) next_state = FIXUP;
      FIXUP:   next_state = DONE;
      DONE: begin
        rspValid = 1'b1;
        if (rspReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result selection: special cases resolve in SETUP, normal ones in FIXUP.
  logic             res_load, res_dbz;
  logic [WIDTH-1:0] res_next, q_fix, r_fix;

  always_comb begin
    q_fix    = q_neg_q ? (~dq_q + 1'b1) : dq_q;
    r_fix    = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    res_load = 1'b0;
    res_dbz  = 1'b0;
    res_next = result_q;
    if (state == SETUP && b_zero) begin
      res_load = 1'b1;
      res_dbz  = 1'b1;
      res_next = is_mod ? a_q : '1;
    end else if (state == SETUP && ovf) begin
      res_load = 1'b1;
      res_next = is_mod ? '0 : MOST_NEG;
    end else if (state == FIXUP) begin
      res_load = 1'b1;
      res_next = is_mod ? r_fix : q_fix;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      b_mag_q  <= '0;
      rem_q    <= '0;
      dq_q     <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        SETUP: begin
          b_mag_q <= b_mag;
          q_neg_q <= signed_op && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          r_neg_q <= signed_op && a_q[WIDTH-1];
          rem_q   <= '0;
`ifdef ITERATIVE_DIVIDER_EARLY_OUT_EN
          // Leading zero bits yield zero quotient bits and leave the remainder at 0.
          dq_q    <= a_mag << lz;
          cnt_q   <= CNT_W'(WIDTH - 1 - int'(lz));
`else
          dq_q    <= a_mag;
          cnt_q   <= CNT_W'(WIDTH - 1);
`endif
        end
        ITER: begin
          rem_q <= step_rem;
          dq_q  <= {dq_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase

      if (res_load) begin
        result_q <= res_next;
        dbz_q    <= res_dbz;
        zero_q   <= (res_next == '0);
        neg_q    <= res_next[WIDTH-1];
      end
    end
  end

  assign result    = result_q;
  assign divByZero = dbz_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = 1'b0;
  assign fsm_state = state;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed cases, randomized
// operations against an arithmetic reference model, backpressure and reset.
module tb_iterative_divider;
  import iterative_divider_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         reqValid = 1'b0;
  logic         reqReady;
  opcode_t      op = OP_ADD;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         rspValid;
  logic         rspReady = 1'b0;
  logic [W-1:0] result;
  logic         divByZero, zero, negative, carry;
  div_state_t   fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .op        (op),
    .a         (a),
    .b         (b),
    .rspValid  (rspValid),
    .rspReady  (rspReady),
    .result    (result),
    .divByZero (divByZero),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic on the operand values.
  function automatic void model(input opcode_t o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] r, output logic dbz);
    long_t sa, sb;
    sa  = long_t'(av);
    sb  = long_t'(bv);
    dbz = (bv == '0);
    if (bv == '0) begin
      r = (o == OP_UDIV || o == OP_SDIV) ? '1 : av;
    end else begin
      case (o)
        OP_UDIV: r = av / bv;
        OP_UMOD: r = av % bv;
        OP_SDIV: r = (av == MIN_NEG && bv == '1) ? MIN_NEG : ulong_t'(sa / sb);
        OP_SMOD: r = (av == MIN_NEG && bv == '1) ? '0 : ulong_t'(sa % sb);
        default: r = '0;
      endcase
    end
  endfunction

  function automatic int exp_latency(input opcode_t o, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] mag;
    int lzc;
    if (bv == '0) return 1;
    if ((o == OP_SDIV || o == OP_SMOD) && av == MIN_NEG && bv == '1) return 1;
    mag = ((o == OP_SDIV || o == OP_SMOD) && av[W-1]) ? -av : av;
    lzc = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (mag[i]) begin
        lzc = W - 1 - i;
        break;
      end
    end
`ifdef ITERATIVE_DIVIDER_EARLY_OUT_EN
    return 2 + W - lzc;
`else
    if (lzc < 0) return 0;
    return 2 + W;
`endif
  endfunction

  // Driver: issue one request, wait for the response, optionally consume it.
  // lat = rising edges from the accept edge until rspValid is seen.
  task automatic run_op(input opcode_t o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit consume, output logic [W-1:0] res, output logic dbz,
                        output logic zr, output logic ng, output logic cy, output int lat);
    @(negedge clk);
    op = o; a = av; b = bv; reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 0;
    while (!rspValid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!rspValid) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: rspValid=%0b after %0d cycles, required 1", rspValid, lat);
    end
    res = result; dbz = divByZero; zr = zero; ng = negative; cy = carry;
    if (consume) begin
      rspReady = 1'b1;
      @(negedge clk);
      rspReady = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #12;
    n_checks++;
    if ({reqReady, rspValid, divByZero, zero, negative, carry} !== 6'b100100 || result !== '0
        || fsm_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0b vld=%0b dbz=%0b z=%0b n=%0b c=%0b res=%h st=%0d, required 1 0 0 1 0 0 0 IDLE",
               reqReady, rspValid, divByZero, zero, negative, carry, result, fsm_state);
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_udiv_basic();
    logic [W-1:0] r; logic d, z, n, c; int lat;
    run_op(OP_UDIV, 64'd100, 64'd7, 1'b1, r, d, z, n, c, lat);
    n_checks++;
    if (r !== 64'd14 || z !== 1'b0 || n !== 1'b0 || d !== 1'b0 || c !== 1'b0) begin
      n_fail++;
      $display("FAIL udiv_100_7: res=%0d z=%0b n=%0b dbz=%0b c=%0b, required 14 0 0 0 0", r, z, n, d, c);
    end
    n_checks++;
    if (lat !== exp_latency(OP_UDIV, 64'd100, 64'd7)) begin
      n_fail++;
      $display("FAIL udiv_latency: got %0d cycles, required %0d", lat, exp_latency(OP_UDIV, 64'd100, 64'd7));
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] r; logic d, z, n, c; int lat;
    run_op(OP_SMOD, -64'sd100, 64'd7, 1'b1, r, d, z, n, c, lat);
    n_checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || n !== 1'b1 || z !== 1'b0 || d !== 1'b0) begin
      n_fail++;
      $display("FAIL smod_m100_7: res=%h n=%0b z=%0b dbz=%0b, required fffffffffffffffe 1 0 0", r, n, z, d);
    end
    run_op(OP_SDIV, -64'sd100, 64'd7, 1'b1, r, d, z, n, c, lat);
    n_checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFF2 || n !== 1'b1) begin
      n_fail++;
      $display("FAIL sdiv_m100_7: res=%h n=%0b, required fffffffffffffff2 1", r, n);
    end
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] r; logic d, z, n, c; int lat;
    run_op(OP_UDIV, 64'd5, 64'd0, 1'b1, r, d, z, n, c, lat);
    n_checks++;
    if (r !== '1 || d !== 1'b1 || n !== 1'b1 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL udiv_by_zero: res=%h dbz=%0b n=%0b z=%0b, required ffffffffffffffff 1 1 0", r, d, n, z);
    end
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL dbz_latency: got %0d cycles, required 1", lat);
    end
    run_op(OP_UMOD, 64'd5, 64'd0, 1'b1, r, d, z, n, c, lat);
    n_checks++;
    if (r !== 64'd5 || d !== 1'b1) begin
      n_fail++;
      $display("FAIL umod_by_zero: res=%h dbz=%0b, required 5 1", r, d);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] r; logic d, z, n, c; int lat;
    run_op(OP_SDIV, MIN_NEG, '1, 1'b1, r, d, z, n, c, lat);
    n_checks++;
    if (r !== MIN_NEG || d !== 1'b0 || n !== 1'b1 || lat !== 1) begin
      n_fail++;
      $display("FAIL sdiv_overflow: res=%h dbz=%0b n=%0b lat=%0d, required 8000000000000000 0 1 1", r, d, n, lat);
    end
    run_op(OP_SMOD, MIN_NEG, '1, 1'b1, r, d, z, n, c, lat);
    n_checks++;
    if (r !== '0 || z !== 1'b1 || d !== 1'b0 || n !== 1'b0) begin
      n_fail++;
      $display("FAIL smod_overflow: res=%h z=%0b dbz=%0b n=%0b, required 0 1 0 0", r, z, d, n);
    end
  endtask

  task automatic test_random();
    opcode_t ops[4];
    logic [W-1:0] av, bv, er, r; logic ed, d, z, n, c; int lat, el;
    ops[0] = OP_UDIV; ops[1] = OP_UMOD; ops[2] = OP_SDIV; ops[3] = OP_SMOD;
    for (int i = 0; i < 24; i++) begin
      av = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) av = W'($urandom_range(0, 1000));
      case ($urandom_range(0, 4))
        0: bv = W'($urandom_range(1, 20));
        1: bv = -W'($urandom_range(1, 20));
        2: bv = '0;
        default: bv = {$urandom, $urandom} >> $urandom_range(0, 60);
      endcase
      model(ops[i % 4], av, bv, er, ed);
      el = exp_latency(ops[i % 4], av, bv);
      run_op(ops[i % 4], av, bv, 1'b1, r, d, z, n, c, lat);
      n_checks++;
      if (r !== er || d !== ed || z !== (er == '0) || n !== er[W-1] || c !== 1'b0 || lat !== el) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: res=%h dbz=%0b z=%0b n=%0b c=%0b lat=%0d, required %h %0b %0b %0b 0 %0d",
                 i, ops[i % 4], av, bv, r, d, z, n, c, lat, er, ed, (er == '0), er[W-1], el);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r; logic d, z, n, c; int lat;
    int bad;
    run_op(OP_UDIV, 64'd1000, 64'd10, 1'b0, r, d, z, n, c, lat);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (result !== 64'd100 || divByZero !== 1'b0 || zero !== 1'b0 || negative !== 1'b0
          || rspValid !== 1'b1 || reqReady !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d unstable cycles of 10, required 0", bad);
    end
    // Offer a new request while the response is being consumed: it must not be taken.
    rspReady = 1'b1; reqValid = 1'b1; op = OP_UDIV; a = 64'd50; b = 64'd5;
    @(negedge clk);
    rspReady = 1'b0; reqValid = 1'b0;
    n_checks++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0 || fsm_state !== IDLE || result !== 64'd100) begin
      n_fail++;
      $display("FAIL backpressure_release: rdy=%0b vld=%0b st=%0d res=%0d, required 1 0 IDLE 100",
               reqReady, rspValid, fsm_state, result);
    end
  endtask

  task automatic test_non_div_op();
    int bad;
    @(negedge clk);
    op = OP_ADD; a = 64'd1; b = 64'd2; reqValid = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rspValid !== 1'b0 || reqReady !== 1'b1 || result !== 64'd100) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL non_div_dropped: %0d bad cycles of 5, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_iter();
    logic [W-1:0] r; logic d, z, n, c; int lat;
    @(negedge clk);
    op = OP_UDIV; a = {$urandom, $urandom}; b = 64'd3; reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    repeat (29) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    n_checks++;
    if (rspValid !== 1'b0 || reqReady !== 1'b1 || result !== '0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_iter: vld=%0b rdy=%0b res=%h z=%0b, required 0 1 0 1", rspValid, reqReady, result, zero);
    end
    @(negedge clk);
    rstN = 1'b1;
    run_op(OP_UDIV, 64'd9, 64'd3, 1'b1, r, d, z, n, c, lat);
    n_checks++;
    if (r !== 64'd3 || lat !== exp_latency(OP_UDIV, 64'd9, 64'd3)) begin
      n_fail++;
      $display("FAIL after_reset_udiv_9_3: res=%0d lat=%0d, required 3 %0d", r, lat, exp_latency(OP_UDIV, 64'd9, 64'd3));
    end
  endtask

  initial begin
    test_reset();
    test_udiv_basic();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_backpressure();
    test_non_div_op();
    test_random();
    test_reset_mid_iter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
